// File: rtl/alu_core.sv
// alu_core: registered integer ALU with carry/zero/negative/overflow flags
// Ports:
//   clk, rst_n (sync active-low)   in_valid, opperand_1, opperand_2, opcode
//   alu_out, out_valid             carry, zero, negative, overflow
module alu_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] opperand_1,
  input  logic [WIDTH-1:0] opperand_2,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] alu_out,
  output logic             out_valid,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);
  localparam int SW = $clog2(WIDTH);
  logic [SW-1:0]    sh;
  logic [WIDTH:0]   sum, dif, shl, shr;
  logic [WIDTH-1:0] res;
  logic             c, v;
  assign sh  = opperand_2[SW-1:0];
  assign sum = {1'b0, opperand_1} + {1'b0, opperand_2};
  assign dif = {1'b0, opperand_1} - {1'b0, opperand_2};
  // One guard bit catches the last bit shifted out; it stays 0 for a zero shift.
  assign shl = {1'b0, opperand_1} << sh;
  assign shr = {opperand_1, 1'b0} >> sh;
  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (opcode)
      3'b000: begin
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (opperand_1[WIDTH-1] == opperand_2[WIDTH-1]) && (res[WIDTH-1] != opperand_1[WIDTH-1]);
      end
      3'b001: begin
        res = dif[WIDTH-1:0];
        c   = dif[WIDTH];
        v   = (opperand_1[WIDTH-1] != opperand_2[WIDTH-1]) && (res[WIDTH-1] != opperand_1[WIDTH-1]);
      end
      3'b010: res = opperand_1 & opperand_2;
      3'b011: res = opperand_1 | opperand_2;
      3'b100: res = opperand_1 ^ opperand_2;
      3'b101: res = ~opperand_1;
      3'b110: begin
        res = shl[WIDTH-1:0];
        c   = shl[WIDTH];
      end
      default: begin
        res = shr[WIDTH:1];
        c   = shr[0];
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_out   <= '0;
      out_valid <= 1'b0;
      carry     <= 1'b0;
      zero      <= 1'b1;
      negative  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        alu_out  <= res;
        carry    <= c;
        zero     <= (res == '0);
        negative <= res[WIDTH-1];
        overflow <= v;
      end
    end
  end
endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: randomized self-checking bench for alu_core against an arithmetic model
module tb_alu_core;
  logic       clk = 1'b0;
  logic       rst_n, in_valid;
  logic [3:0] opperand_1, opperand_2;
  logic [2:0] opcode;
  logic [3:0] alu_out;
  logic       out_valid, carry, zero, negative, overflow;
  int checks = 0;
  int errors = 0;
  int e_out, e_v, e_c, e_z, e_n, e_o;
  alu_core #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .opperand_1(opperand_1), .opperand_2(opperand_2), .opcode(opcode),
    .alu_out(alu_out), .out_valid(out_valid), .carry(carry),
    .zero(zero), .negative(negative), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int sgn(input int x);
    return x >= 8 ? x - 16 : x;
  endfunction
  task automatic model(input logic r, input logic v, input int op, input int a, input int b);
    int s, n;
    if (!r) begin
      e_out = 0; e_v = 0; e_c = 0; e_z = 1; e_n = 0; e_o = 0;
    end else if (!v) begin
      e_v = 0;
    end else begin
      e_v = 1; e_c = 0; e_o = 0;
      n = b % 4;
      case (op)
        0: begin
          e_out = (a + b) % 16; e_c = (a + b) >= 16 ? 1 : 0;
          s = sgn(a) + sgn(b); e_o = (s > 7 || s < -8) ? 1 : 0;
        end
        1: begin
          e_out = (a - b + 16) % 16; e_c = a < b ? 1 : 0;
          s = sgn(a) - sgn(b); e_o = (s > 7 || s < -8) ? 1 : 0;
        end
        2: e_out = a & b;
        3: e_out = a | b;
        4: e_out = a ^ b;
        5: e_out = 15 - a;
        6: begin
          e_out = (a * (1 << n)) % 16; e_c = n > 0 ? (a >> (4 - n)) & 1 : 0;
        end
        default: begin
          e_out = a / (1 << n); e_c = n > 0 ? (a >> (n - 1)) & 1 : 0;
        end
      endcase
      e_z = e_out == 0 ? 1 : 0;
      e_n = e_out >= 8 ? 1 : 0;
    end
  endtask
  task automatic step(input logic r, input logic v, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    rst_n = r; in_valid = v; opcode = op; opperand_1 = a; opperand_2 = b;
    @(posedge clk);
    model(r, v, int'(op), int'(a), int'(b));
    #1;
    check("alu_out", alu_out, e_out);
    check("valid_flags", {out_valid, carry, zero, negative, overflow}, {e_v[0], e_c[0], e_z[0], e_n[0], e_o[0]});
  endtask
  task automatic dir(input string tag, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic [3:0] r, input logic [3:0] f);
    step(1, 1, op, a, b);
    check({tag, "_res"}, alu_out, r);
    check({tag, "_cznv"}, {out_valid, carry, zero, negative, overflow}, {1'b1, f});
  endtask
  initial begin
    step(0, 1, 3'd0, 4'h3, 4'h4);
    step(0, 1, 3'd0, 4'h3, 4'h4);
    check("reset_state", {alu_out, out_valid, carry, zero, negative, overflow}, 10'b0000_0_0_1_0_0);
    dir("add", 3'd0, 4'h3, 4'h1, 4'h4, 4'b0000);
    dir("sub", 3'd1, 4'h3, 4'h1, 4'h2, 4'b0000);
    dir("and", 3'd2, 4'h3, 4'h1, 4'h1, 4'b0000);
    dir("or",  3'd3, 4'h3, 4'h1, 4'h3, 4'b0000);
    dir("xor", 3'd4, 4'h3, 4'h1, 4'h2, 4'b0000);
    dir("not", 3'd5, 4'h3, 4'h1, 4'hC, 4'b0010);
    dir("add_carry", 3'd0, 4'hF, 4'h1, 4'h0, 4'b1100);
    dir("add_ovf",   3'd0, 4'h7, 4'h1, 4'h8, 4'b0011);
    dir("sub_borrow",3'd1, 4'h0, 4'h1, 4'hF, 4'b1010);
    dir("sub_ovf",   3'd1, 4'h8, 4'h1, 4'h7, 4'b0001);
    dir("shl1",      3'd6, 4'h9, 4'h1, 4'h2, 4'b1000);
    dir("shr3",      3'd7, 4'h9, 4'h3, 4'h1, 4'b0000);
    dir("shl_hi_b",  3'd6, 4'h9, 4'h4, 4'h9, 4'b0010);
    dir("hs1", 3'd0, 4'h2, 4'h3, 4'h5, 4'b0000);
    dir("hs2", 3'd1, 4'h9, 4'h2, 4'h7, 4'b0001);
    step(1, 0, 3'd4, 4'hA, 4'h5);
    check("gap_hold", {out_valid, alu_out, overflow}, {1'b0, 4'h7, 1'b1});
    dir("hs4", 3'd3, 4'h4, 4'h1, 4'h5, 4'b0000);
    dir("pre_rst", 3'd0, 4'h5, 4'h6, 4'hB, 4'b0011);
    step(0, 1, 3'd0, 4'h1, 4'h1);
    check("mid_reset", {alu_out, out_valid, carry, zero, negative, overflow}, 10'b0000_0_0_1_0_0);
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
